// File: rtl/core_memory_pkg.sv
// core_memory_pkg: shared state encoding, legal byte-select set and lane helpers for the memory responder.
package core_memory_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_FAULT, S_BREAK} state_t;
  localparam int CNT_W = 4;
  localparam logic [3:0] BS_B0 = 4'b0001;
  localparam logic [3:0] BS_B1 = 4'b0010;
  localparam logic [3:0] BS_B2 = 4'b0100;
  localparam logic [3:0] BS_B3 = 4'b1000;
  localparam logic [3:0] BS_LO = 4'b0011;
  localparam logic [3:0] BS_HI = 4'b1100;
  localparam logic [3:0] BS_W  = 4'b1111;
  function automatic logic legal_byte_select(input logic [3:0] bs);
    return bs inside {BS_B0, BS_B1, BS_B2, BS_B3, BS_LO, BS_HI, BS_W};
  endfunction
  function automatic logic [31:0] lane_mask(input logic [3:0] bs);
    return {{8{bs[3]}}, {8{bs[2]}}, {8{bs[1]}}, {8{bs[0]}}};
  endfunction
endpackage

// File: rtl/memory_request_decoder.sv
// memory_request_decoder: combinational range, alignment, byte-select and direction check plus SRAM word offset.
module memory_request_decoder
  import core_memory_pkg::*;
#(
  parameter logic [31:0] ADDRESS_BASE  = 32'h0000_0000,
  parameter int          ADDRESS_WIDTH = 10
) (
  input  logic [31:0]              address_i,
  input  logic [3:0]               byte_select_i,
  input  logic                     read_i,
  input  logic                     write_i,
  output logic                     valid_o,
  output logic [ADDRESS_WIDTH-1:0] word_o
);
  logic [31:0] offset;
  // Base is bank-aligned, so the low offset bits double as the alignment check.
  assign offset  = address_i - ADDRESS_BASE;
  assign word_o  = offset[ADDRESS_WIDTH+1:2];
  assign valid_o = (offset[31:ADDRESS_WIDTH+2] == '0) && (offset[1:0] == 2'b00)
                   && legal_byte_select(byte_select_i) && !(read_i && write_i);
endmodule

// File: rtl/core_memory_responder.sv
// core_memory_responder: validates core memory requests and services them from a single-port SRAM with wait states.
// Define BREAKPOINT_EN to add the address-breakpoint compare and its breakpoint_* ports.
module core_memory_responder
  import core_memory_pkg::*;
#(
  parameter logic [31:0] ADDRESS_BASE  = 32'h0000_0000,
  parameter int          ADDRESS_WIDTH = 10,
  parameter int          WAIT_STATES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              memoryAddress,
  input  logic [3:0]               memoryByteSelect,
  input  logic                     memoryWriteEnable,
  input  logic                     memoryReadEnable,
  input  logic [31:0]              memoryDataWrite,
  output logic [31:0]              memoryDataRead,
  output logic                     memoryBusy,
  output logic                     memoryAccessFault,
  output logic                     addressBreakpoint,
  output logic [ADDRESS_WIDTH-1:0] sram_address,
  output logic                     sram_enable,
  output logic                     sram_writeEnable,
  output logic [3:0]               sram_writeMask,
  output logic [31:0]              sram_dataWrite,
  input  logic [31:0]              sram_dataRead
`ifdef BREAKPOINT_EN
  ,
  input  logic [31:0]              breakpoint_address,
  input  logic                     breakpoint_enable
`endif
);
  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic req, valid, strobe, bp_hit, done;
  logic [ADDRESS_WIDTH-1:0] word;
  logic [31:0] rd_src;
  assign req = memoryReadEnable || memoryWriteEnable;
`ifdef BREAKPOINT_EN
  assign bp_hit = breakpoint_enable && (memoryAddress[31:2] == breakpoint_address[31:2]);
`else
  assign bp_hit = 1'b0;
`endif
  memory_request_decoder #(
    .ADDRESS_BASE (ADDRESS_BASE),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_decoder (
    .address_i    (memoryAddress),
    .byte_select_i(memoryByteSelect),
    .read_i       (memoryReadEnable),
    .write_i      (memoryWriteEnable),
    .valid_o      (valid),
    .word_o       (word)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    strobe  = 1'b0;
    case (state_q)
      S_IDLE: if (req) begin
        if (!valid) state_d = S_FAULT;
        else if (bp_hit) state_d = S_BREAK;
        else begin
          strobe  = 1'b1;
          cnt_d   = WS;
          state_d = (WS != '0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: if (!req) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WS) data_d = sram_dataRead;
        if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end
  // Outputs are forced quiet while reset is held, even with a request still present.
  always_comb begin
    done              = !rst && (state_q == S_DONE);
    rd_src            = (WS == '0) ? sram_dataRead : data_q;
    memoryDataRead    = (done && !memoryWriteEnable) ? (rd_src & lane_mask(memoryByteSelect)) : '0;
    memoryBusy        = !rst && req && !(state_q inside {S_DONE, S_FAULT, S_BREAK});
    memoryAccessFault = !rst && (state_q == S_FAULT);
    addressBreakpoint = !rst && (state_q == S_BREAK);
    sram_enable       = !rst && strobe;
    sram_writeEnable  = sram_enable && memoryWriteEnable;
    sram_writeMask    = sram_enable ? memoryByteSelect : '0;
    sram_address      = sram_enable ? word : '0;
    sram_dataWrite    = sram_enable ? memoryDataWrite : '0;
  end
endmodule

// File: tb/tb_core_memory_responder.sv
// tb_core_memory_responder: directed scoreboard bench with a behavioural SRAM; define BREAKPOINT_EN to cover breakpoints.
module tb_core_memory_responder;
  localparam int WS = 1;
  typedef struct packed {
    logic [1:0]  flags;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] memoryAddress = '0;
  logic [3:0]  memoryByteSelect = '0;
  logic        memoryWriteEnable = 1'b0;
  logic        memoryReadEnable = 1'b0;
  logic [31:0] memoryDataWrite = '0;
  logic [31:0] memoryDataRead;
  logic        memoryBusy, memoryAccessFault, addressBreakpoint;
  logic [9:0]  sram_address;
  logic        sram_enable, sram_writeEnable;
  logic [3:0]  sram_writeMask;
  logic [31:0] sram_dataWrite;
  logic [31:0] sram_dataRead = '0;
`ifdef BREAKPOINT_EN
  logic [31:0] breakpoint_address = '0;
  logic        breakpoint_enable = 1'b0;
`endif
  logic [31:0] mem [0:1023];
  int checks = 0, failures = 0, comps = 0, strobes = 0, cyc = 0;
  exp_t exp_q[$];

  core_memory_responder #(
    .ADDRESS_BASE (32'h0000_0000),
    .ADDRESS_WIDTH(10),
    .WAIT_STATES  (WS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .memoryAddress    (memoryAddress),
    .memoryByteSelect (memoryByteSelect),
    .memoryWriteEnable(memoryWriteEnable),
    .memoryReadEnable (memoryReadEnable),
    .memoryDataWrite  (memoryDataWrite),
    .memoryDataRead   (memoryDataRead),
    .memoryBusy       (memoryBusy),
    .memoryAccessFault(memoryAccessFault),
    .addressBreakpoint(addressBreakpoint),
    .sram_address     (sram_address),
    .sram_enable      (sram_enable),
    .sram_writeEnable (sram_writeEnable),
    .sram_writeMask   (sram_writeMask),
    .sram_dataWrite   (sram_dataWrite),
    .sram_dataRead    (sram_dataRead)
`ifdef BREAKPOINT_EN
    ,
    .breakpoint_address(breakpoint_address),
    .breakpoint_enable (breakpoint_enable)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port SRAM: read data appears the cycle after the strobe, writes honour the byte mask.
  always @(posedge clk) begin
    if (sram_enable) begin
      strobes <= strobes + 1;
      sram_dataRead <= mem[sram_address];
      for (int b = 0; b < 4; b++)
        if (sram_writeEnable && sram_writeMask[b]) mem[sram_address][8*b+:8] <= sram_dataWrite[8*b+:8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (memoryReadEnable || memoryWriteEnable) && !memoryBusy) begin
      exp_t e;
      comps++;
      chk("cpl_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpl_flags", 64'({memoryAccessFault, addressBreakpoint}), 64'(e.flags));
        chk("cpl_data", 64'(memoryDataRead), 64'(e.data));
        chk("cpl_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // fl: 2'b00 normal, 2'b10 fault, 2'b01 breakpoint; n completions while the request is held.
  task automatic access(input logic [31:0] a, input logic [3:0] bs, input logic r, input logic w,
                        input logic [31:0] wd, input logic [1:0] fl, input logic [31:0] ed, input int n);
    int lat, s0, target;
    lat = (fl == 2'b00) ? 1 + WS : 1;
    @(posedge clk);
    #1;
    memoryAddress = a;
    memoryByteSelect = bs;
    memoryReadEnable = r;
    memoryWriteEnable = w;
    memoryDataWrite = wd;
    s0 = strobes;
    target = comps + n;
    for (int j = 0; j < n; j++) exp_q.push_back('{fl, ed, 32'(cyc + lat + j * (lat + 1))});
    for (int i = 0; i < 20 * n && comps < target; i++) begin
      @(negedge clk);
      #1;
    end
    memoryReadEnable = 1'b0;
    memoryWriteEnable = 1'b0;
    chk("timeout", 64'(comps), 64'(target));
    chk("strobes", 64'(strobes - s0), 64'((fl == 2'b00) ? n : 0));
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h040] = 32'hDEADBEEF;
    mem[10'h041] = 32'hAABBCCDD;
    mem[10'h3FF] = 32'hCAFE0001;
    memoryAddress = 32'h104;
    memoryByteSelect = 4'hF;
    memoryWriteEnable = 1'b1;
    memoryDataWrite = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bus", 64'({memoryDataRead, memoryBusy, memoryAccessFault, addressBreakpoint}), 64'd0);
    chk("reset_sram", 64'({sram_address, sram_enable, sram_writeEnable, sram_writeMask}), 64'd0);
    chk("reset_wdata", 64'(sram_dataWrite), 64'd0);
    memoryWriteEnable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_no_strobe", 64'(strobes), 64'd0);

    access(32'h100, 4'hF, 1, 0, 0, 2'b00, 32'hDEADBEEF, 1);
    access(32'h104, 4'h3, 0, 1, 32'h12345678, 2'b00, 32'h0, 1);
    chk("write_mem", 64'(mem[10'h041]), 64'hAABB5678);
    access(32'h104, 4'hF, 1, 0, 0, 2'b00, 32'hAABB5678, 1);
    access(32'h100, 4'hC, 1, 0, 0, 2'b00, 32'hDEAD0000, 1);
    access(32'h100, 4'h2, 1, 0, 0, 2'b00, 32'h0000BE00, 1);
    access(32'hFFC, 4'hF, 1, 0, 0, 2'b00, 32'hCAFE0001, 1);
    access(32'h1000, 4'hF, 1, 0, 0, 2'b10, 32'h0, 1);
    access(32'h102, 4'hF, 1, 0, 0, 2'b10, 32'h0, 1);
    access(32'h100, 4'h6, 1, 0, 0, 2'b10, 32'h0, 1);
    access(32'h100, 4'h0, 1, 0, 0, 2'b10, 32'h0, 1);
    access(32'h100, 4'hF, 1, 1, 32'h55555555, 2'b10, 32'h0, 1);
    chk("fault_no_write", 64'(mem[10'h040]), 64'hDEADBEEF);
    access(32'h100, 4'hF, 1, 0, 0, 2'b00, 32'hDEADBEEF, 3);
    access(32'h2000, 4'hF, 1, 0, 0, 2'b10, 32'h0, 2);

    @(posedge clk);
    #1;
    memoryAddress = 32'h100;
    memoryByteSelect = 4'hF;
    memoryReadEnable = 1'b1;
    memoryDataWrite = 32'hA5A5A5A5;
    s0 = strobes;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_bus", 64'({memoryDataRead, memoryBusy, memoryAccessFault, addressBreakpoint}), 64'd0);
    chk("midrst_sram", 64'({sram_address, sram_enable, sram_writeEnable, sram_writeMask}), 64'd0);
    chk("midrst_wdata", 64'(sram_dataWrite), 64'd0);
    memoryReadEnable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_strobes", 64'(strobes - s0), 64'd1);
    access(32'h104, 4'hF, 1, 0, 0, 2'b00, 32'hAABB5678, 1);

    @(posedge clk);
    #1;
    memoryAddress = 32'h104;
    memoryReadEnable = 1'b1;
    @(posedge clk);
    #1;
    memoryReadEnable = 1'b0;
    access(32'h100, 4'hF, 1, 0, 0, 2'b00, 32'hDEADBEEF, 1);

`ifdef BREAKPOINT_EN
    breakpoint_address = 32'h108;
    breakpoint_enable = 1'b1;
    access(32'h10A, 4'hF, 1, 0, 0, 2'b10, 32'h0, 1);
    access(32'h108, 4'hF, 1, 0, 0, 2'b01, 32'h0, 1);
    access(32'h10C, 4'hF, 1, 0, 0, 2'b00, 32'h0, 1);
    breakpoint_enable = 1'b0;
    access(32'h108, 4'hF, 1, 0, 0, 2'b00, 32'h0, 1);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
